siso_shift_ctrl: RTL and testbench

Sequencing controller for the 4-stage serial-in/serial-out shift register. It accepts a parallel word over a valid/ready handshake and shifts it MSB-first into the register's `serial_in`. It then collects the bits returning on the register's `serial_out` and presents the reassembled word with a one-cycle `out_valid` pulse. It sits between the parallel producer/consumer logic and the shift-register datapath, which it owns exclusively.

---
 rtl/siso_shift_ctrl_if.sv | 37 +++
 rtl/siso_shift_ctrl.sv | 94 +++++++++
 tb/tb_siso_shift_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/siso_shift_ctrl_if.sv
// Parallel handshake plus shift-register link between siso_shift_ctrl and its surroundings.
// Build option SISO_CTRL_CHECK_EN adds the sticky loopback mismatch flag.
interface siso_shift_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sr_serial_in;
  logic             sr_serial_out;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef SISO_CTRL_CHECK_EN
  logic             mismatch;

  modport master (
    input  in_valid, in_data, sr_serial_out,
    output in_ready, sr_serial_in, out_valid, out_data, busy, mismatch
  );

  modport slave (
    output in_valid, in_data, sr_serial_out,
    input  in_ready, sr_serial_in, out_valid, out_data, busy, mismatch
  );
`else
  modport master (
    input  in_valid, in_data, sr_serial_out,
    output in_ready, sr_serial_in, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, sr_serial_out,
    input  in_ready, sr_serial_in, out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/siso_shift_ctrl.sv
// Serialises a parallel word MSB-first into a DEPTH-stage SISO register and reassembles it on return.
// Build option SISO_CTRL_CHECK_EN compares the returned word against the sent word (sticky mismatch).
module siso_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  siso_shift_ctrl_if.master bus
);

  localparam int CW = $clog2(WIDTH + DEPTH);
  localparam logic [CW-1:0] LastShift = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FirstCap  = CW'(DEPTH);
  localparam logic [CW-1:0] LastCnt   = CW'(WIDTH + DEPTH - 1);

  typedef enum logic [1:0] {
    Idle,
    Shift,
    Drain
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] rx_d;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
`ifdef SISO_CTRL_CHECK_EN
  logic [WIDTH-1:0] chk_q;
  logic             mismatch_q;
`endif

  // rx_d is the receive word including the bit arriving at this edge, so completion can publish it directly.
  assign rx_d = {rx_q[WIDTH-2:0], bus.sr_serial_out};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= Idle;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef SISO_CTRL_CHECK_EN
      chk_q       <= '0;
      mismatch_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (bus.in_valid) begin
            tx_q    <= bus.in_data;
            cnt_q   <= '0;
            state_q <= Shift;
`ifdef SISO_CTRL_CHECK_EN
            chk_q   <= bus.in_data;
`endif
          end
        end
        Shift, Drain: begin
          cnt_q <= cnt_q + CW'(1);
          if (state_q == Shift) begin
            tx_q <= {tx_q[WIDTH-2:0], 1'b0};
            if (cnt_q == LastShift) state_q <= Drain;
          end
          // Capture may overlap Shift when the register is shorter than the word.
          if (cnt_q >= FirstCap) rx_q <= rx_d;
          if (cnt_q == LastCnt) begin
            out_data_q  <= rx_d;
            out_valid_q <= 1'b1;
            state_q     <= Idle;
`ifdef SISO_CTRL_CHECK_EN
            mismatch_q  <= mismatch_q | (rx_d != chk_q);
`endif
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == Idle);
  assign bus.busy         = (state_q != Idle);
  assign bus.sr_serial_in = (state_q == Shift) & tx_q[WIDTH-1];
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
`ifdef SISO_CTRL_CHECK_EN
  assign bus.mismatch     = mismatch_q;
`endif

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench for siso_shift_ctrl with behavioural 4-stage and 2-stage shift registers attached.
// Defining SISO_CTRL_CHECK_EN adds the forced-zero loopback mismatch scenario.
module tb_siso_shift_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic forceZero = 1'b0;
  logic [3:0] srA = '0;
  logic [1:0] srB = '0;
  int assertCount = 0;
  int failCount = 0;

  siso_shift_ctrl_if #(.WIDTH(4)) busA ();
  siso_shift_ctrl_if #(.WIDTH(4)) busB ();

  siso_shift_ctrl #(.WIDTH(4), .DEPTH(4)) dutA (.clk(clk), .reset(reset), .bus(busA));
  siso_shift_ctrl #(.WIDTH(4), .DEPTH(2)) dutB (.clk(clk), .reset(reset), .bus(busB));

  always #5 clk = ~clk;

  // Behavioural shift registers; they are never reset, matching the real datapath.
  always @(posedge clk) begin
    srA <= {srA[2:0], busA.sr_serial_in};
    srB <= {srB[0], busB.sr_serial_in};
  end
  assign busA.sr_serial_out = forceZero ? 1'b0 : srA[3];
  assign busB.sr_serial_out = srB[1];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with dutA idle; sends one word and follows it to completion.
  task automatic applyStimulus(input string tag, input logic [3:0] word, input logic [3:0] expOut);
    busA.in_valid = 1'b1;
    busA.in_data  = word;
    @(negedge clk);
    busA.in_valid = 1'b0;
    checkOutput({tag, " busy after accept"}, 32'(busA.busy), 32'd1);
    checkOutput({tag, " ser bit0"}, 32'(busA.sr_serial_in), 32'(word[3]));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s ser k%0d", tag, k), 32'(busA.sr_serial_in),
                  (k < 4) ? 32'(word[3-k]) : 32'd0);
      checkOutput($sformatf("%s out_valid k%0d", tag, k), 32'(busA.out_valid), 32'(k == 8));
    end
    checkOutput({tag, " out_data"}, 32'(busA.out_data), 32'(expOut));
    checkOutput({tag, " in_ready at done"}, 32'(busA.in_ready), 32'd1);
  endtask

  initial begin
    busA.in_valid = 1'b0;
    busA.in_data  = '0;
    busB.in_valid = 1'b0;
    busB.in_data  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst in_ready", 32'(busA.in_ready), 32'd1);
    checkOutput("rst busy", 32'(busA.busy), 32'd0);
    checkOutput("rst out_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("rst out_data", 32'(busA.out_data), 32'd0);
    checkOutput("rst ser", 32'(busA.sr_serial_in), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single word round trip
    applyStimulus("w1011", 4'b1011, 4'b1011);

    // Back-to-back with in_valid held: second accept 9 cycles after the first
    busA.in_valid = 1'b1;
    busA.in_data  = 4'b1011;
    @(negedge clk);
    busA.in_data  = 4'b0110;
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("b2b in_ready low c%0d", k - 1), 32'(busA.in_ready), 32'd0);
      @(negedge clk);
    end
    checkOutput("b2b first out_valid", 32'(busA.out_valid), 32'd1);
    checkOutput("b2b first out_data", 32'(busA.out_data), 32'hb);
    checkOutput("b2b in_ready with out_valid", 32'(busA.in_ready), 32'd1);
    @(negedge clk);
    busA.in_valid = 1'b0;
    checkOutput("b2b second accept busy", 32'(busA.busy), 32'd1);
    checkOutput("b2b second ser bit0", 32'(busA.sr_serial_in), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) checkOutput($sformatf("b2b2 in_ready low k%0d", k), 32'(busA.in_ready), 32'd0);
      @(negedge clk);
    end
    checkOutput("b2b second out_valid", 32'(busA.out_valid), 32'd1);
    checkOutput("b2b second out_data", 32'(busA.out_data), 32'h6);
    @(negedge clk);

    // in_valid pulsed while busy must be ignored
    busA.in_valid = 1'b1;
    busA.in_data  = 4'b0011;
    @(negedge clk);
    busA.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    busA.in_valid = 1'b1;
    busA.in_data  = 4'b1111;
    checkOutput("ign in_ready low", 32'(busA.in_ready), 32'd0);
    @(negedge clk);
    busA.in_valid = 1'b0;
    checkOutput("ign ser bit3", 32'(busA.sr_serial_in), 32'd1);
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ign out_valid k%0d", k), 32'(busA.out_valid), 32'(k == 8));
    end
    checkOutput("ign out_data", 32'(busA.out_data), 32'h3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ign no extra out_valid %0d", k), 32'(busA.out_valid), 32'd0);
      checkOutput($sformatf("ign idle busy %0d", k), 32'(busA.busy), 32'd0);
    end

    // Reset three cycles after accepting 1001
    busA.in_valid = 1'b1;
    busA.in_data  = 4'b1001;
    @(negedge clk);
    busA.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst busy", 32'(busA.busy), 32'd0);
    checkOutput("midrst in_ready", 32'(busA.in_ready), 32'd1);
    checkOutput("midrst out_data", 32'(busA.out_data), 32'd0);
    checkOutput("midrst ser", 32'(busA.sr_serial_in), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst no out_valid %0d", k), 32'(busA.out_valid), 32'd0);
    end
    applyStimulus("w0101", 4'b0101, 4'b0101);

`ifdef SISO_CTRL_CHECK_EN
    // Broken loopback raises a sticky mismatch
    checkOutput("chk mismatch clean", 32'(busA.mismatch), 32'd0);
    forceZero = 1'b1;
    applyStimulus("w1000 forced", 4'b1000, 4'b0000);
    checkOutput("chk mismatch set", 32'(busA.mismatch), 32'd1);
    forceZero = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    checkOutput("chk mismatch sticky", 32'(busA.mismatch), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("chk mismatch cleared", 32'(busA.mismatch), 32'd0);
    @(negedge clk);
`endif

    // DEPTH=2: capture overlaps the shift phase, result 6 cycles after accept
    busB.in_valid = 1'b1;
    busB.in_data  = 4'b1101;
    @(negedge clk);
    busB.in_valid = 1'b0;
    checkOutput("d2 ser bit0", 32'(busB.sr_serial_in), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("d2 out_valid k%0d", k), 32'(busB.out_valid), 32'(k == 6));
    end
    checkOutput("d2 out_data", 32'(busB.out_data), 32'hd);
    checkOutput("d2 in_ready", 32'(busB.in_ready), 32'd1);
    @(negedge clk);
    checkOutput("d2 pulse ends", 32'(busB.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
